// File: rtl/vector_memory_reader.sv
// Vector load engine: gathers LANES consecutive bytes from a 1-cycle synchronous RAM into one vector.
// Optional bounds fault on base+LANES-1 overflow when VECTOR_READER_BOUNDS_CHECK_EN is defined.
module vector_memory_reader #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    memory_base,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic [LANES*8-1:0]   vector_out,
    output logic                 error
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LANE_W-1:0] lane_cnt;
    logic              oob;

    logic              vld_p1;
    logic [LANE_W-1:0] lane_p1;

    function automatic logic [ADDR_W-1:0] lane_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LANE_W-1:0] lane
    );
        return base + ADDR_W'(lane);
    endfunction

`ifdef VECTOR_READER_BOUNDS_CHECK_EN
    logic [ADDR_W:0] last_addr;
    assign last_addr = {1'b0, memory_base} + (ADDR_W + 1)'(LANES - 1);
    assign oob       = last_addr[ADDR_W];
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            base_q    <= '0;
            lane_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= memory_base;
                        lane_cnt <= '0;
                        if (oob) begin
                            // Out-of-range base: report straight away, no memory traffic.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= memory_base;
                            busy      <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (lane_cnt == LAST_LANE) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                    end else begin
                        lane_cnt <= lane_cnt + LANE_W'(1);
                        mem_addr <= lane_addr(base_q, lane_cnt + LANE_W'(1));
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // p1: RAM data for the strobe issued last cycle arrives now; write it into its lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            lane_p1    <= '0;
            vector_out <= '0;
        end else begin
            vld_p1  <= mem_rd_en;
            lane_p1 <= lane_cnt;
            if (vld_p1) begin
                vector_out[{lane_p1, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

`ifdef VECTOR_READER_BOUNDS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= oob;
        end else if (state == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vector_memory_reader.sv
// Directed bench for vector_memory_reader: cycle model + RAM model + literal expectations.
module tb_vector_memory_reader;

    localparam int ADDR_W = 12;
    localparam int LANES  = 16;
    localparam int DONE_N = LANES + 2;
`ifdef VECTOR_READER_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  memory_base;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_rdata;
    logic               busy;
    logic               done;
    logic [LANES*8-1:0] vector_out;
    logic               error;

    vector_memory_reader #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .memory_base(memory_base),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .done(done),
        .vector_out(vector_out),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    initial mem_rdata = 8'h00;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: m_n counts cycles since an accepted load (0 = idle, 1..16 reads, 17 drain, 18 done).
    int                 m_n = 0;
    logic [ADDR_W-1:0]  m_base = '0;
    logic [LANES*8-1:0] m_vec = '0;
    bit                 m_err = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_n   <= 0;
            m_vec <= '0;
            m_err <= 1'b0;
        end else if (m_n == 0) begin
            if (start) begin
                m_base <= memory_base;
                if (BOUNDS && (int'(memory_base) + LANES - 1 > (1 << ADDR_W) - 1)) begin
                    m_n   <= DONE_N;
                    m_err <= 1'b1;
                end else begin
                    m_n <= 1;
                end
            end
        end else begin
            m_n   <= (m_n == DONE_N) ? 0 : m_n + 1;
            m_err <= 1'b0;
            if (m_n + 1 >= 3 && m_n + 1 <= DONE_N)
                m_vec[(m_n - 2) * 8 +: 8] <= mem[(int'(m_base) + m_n - 2) % (1 << ADDR_W)];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rd;
            int exp_addr;
            exp_rd   = (m_n >= 1 && m_n <= LANES);
            exp_addr = exp_rd ? (int'(m_base) + m_n - 1) % (1 << ADDR_W) : 0;
            check("mem_rd_en", 128'(mem_rd_en), 128'(exp_rd));
            check("mem_addr", 128'(mem_addr), 128'(exp_addr));
            check("busy", 128'(busy), 128'(m_n >= 1 && m_n <= LANES + 1));
            check("done", 128'(done), 128'(m_n == DONE_N));
            check("error", 128'(error), 128'(m_err));
            check("vector_out", vector_out, m_vec);
        end
    end

    // Monitor for literal checks.
    int cyc = 0;
    logic [ADDR_W-1:0] addr_q[$];
    int rd_cyc_q[$];
    int done_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_rd_en) begin
            addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        addr_q.delete();
        rd_cyc_q.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic wait_done(output int edges, output bit seen);
        edges = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
    endtask

    logic [LANES*8-1:0] saved_vec;
    int edges;
    bit seen;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        memory_base = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'((i * 7 + 3) & 255);
        for (int k = 0; k < LANES; k++) mem[256 + k] = 8'(k + 1);

        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("reset_vector", vector_out, 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_rd_en", 128'(mem_rd_en), 128'h0);
        check("reset_done", 128'(done), 128'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();

        // Basic load from 0x100.
        clear_mon();
        memory_base = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        memory_base = '0;
        wait_done(edges, seen);
        check("basic_done_seen", 128'(seen), 128'h1);
        check("basic_latency", 128'(edges), 128'd17);
        check("basic_nreads", 128'(addr_q.size()), 128'd16);
        if (addr_q.size() == 16) begin
            check("basic_first_addr", 128'(addr_q[0]), 128'h100);
            check("basic_last_addr", 128'(addr_q[15]), 128'h10F);
        end
        check("basic_vector", vector_out, 128'h100F0E0D0C0B0A090807060504030201);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("basic_hold", vector_out, 128'h100F0E0D0C0B0A090807060504030201);
        check("basic_one_done", 128'(done_cnt), 128'd1);
        tick();

        // Start pulsed while busy is ignored.
        clear_mon();
        memory_base = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        memory_base = 12'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        memory_base = '0;
        repeat (25) tick();
        check("busy_start_done_cnt", 128'(done_cnt), 128'd1);
        check("busy_start_nreads", 128'(addr_q.size()), 128'd16);
        if (addr_q.size() == 16) check("busy_start_addr5", 128'(addr_q[5]), 128'h105);

        // Start held high: new loads only from IDLE after DONE.
        clear_mon();
        memory_base = 12'h100;
        start = 1'b1;
        repeat (45) tick();
        start = 1'b0;
        memory_base = '0;
        repeat (25) tick();
        check("b2b_done_cnt", 128'(done_cnt), 128'd3);
        check("b2b_nreads", 128'(addr_q.size()), 128'd48);
        // Between loads: DRAIN, DONE and the accepting IDLE cycle carry no strobe.
        if (rd_cyc_q.size() == 48) check("b2b_gap", 128'(rd_cyc_q[16] - rd_cyc_q[15]), 128'd4);

        // Reset during read k=7.
        clear_mon();
        memory_base = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        memory_base = '0;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("abort_vector", vector_out, 128'h0);
        check("abort_rd_en", 128'(mem_rd_en), 128'h0);
        check("abort_busy", 128'(busy), 128'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (25) tick();
        check("abort_no_done", 128'(done_cnt), 128'd0);

        // Reset wins over start on the same edge.
        clear_mon();
        rst = 1'b0;
        start = 1'b1;
        memory_base = 12'h100;
        tick();
        rst = 1'b1;
        start = 1'b0;
        memory_base = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_prio_nreads", 128'(addr_q.size()), 128'd0);
        check("rst_prio_busy", 128'(busy), 128'h0);
        tick();

        // Base 0xFF8: wrap, or bounds fault when checking is enabled.
        memory_base = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        memory_base = '0;
        repeat (22) tick();
        saved_vec = vector_out;
        clear_mon();
        memory_base = 12'hFF8;
        start = 1'b1;
        tick();
        start = 1'b0;
        memory_base = '0;
        @(negedge clk);
        if (BOUNDS) begin
            check("oob_done", 128'(done), 128'h1);
            check("oob_error", 128'(error), 128'h1);
            repeat (20) tick();
            check("oob_nreads", 128'(addr_q.size()), 128'd0);
            check("oob_vector_kept", vector_out, saved_vec);
            check("oob_err_cnt", 128'(err_cnt), 128'd1);
        end else begin
            repeat (22) tick();
            check("wrap_nreads", 128'(addr_q.size()), 128'd16);
            if (addr_q.size() == 16) begin
                check("wrap_addr7", 128'(addr_q[7]), 128'hFFF);
                check("wrap_addr8", 128'(addr_q[8]), 128'h000);
                check("wrap_addr15", 128'(addr_q[15]), 128'h007);
            end
            check("wrap_lane7", 128'(vector_out[63:56]), 128'hFC);
            check("wrap_lane8", 128'(vector_out[71:64]), 128'h03);
            check("wrap_no_error", 128'(err_cnt), 128'd0);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
